// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Dynamic branch predictor. A direct-mapped branch target
//               buffer is looked up combinationally with the IF-stage PC and
//               yields the next fetch PC. Resolved branches train the table
//               through per-entry saturating counters. Two performance
//               counters track resolved branches and mispredictions.
// Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//               pc_i                - fetch PC to look up
//               hit_o, pred_taken_o - lookup hit / predicted-taken flag
//               pred_pc_o           - predicted next fetch PC
//               upd_*_i             - branch resolution update
//               cnt_branch_o        - resolved branches since reset
//               cnt_mispred_o       - mispredictions since reset
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             hit_o,
  output logic             pred_taken_o,
  output logic [PC_W-1:0]  pred_pc_o,
  input  logic             upd_valid_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [PC_W-1:0]  upd_target_i,
  input  logic             upd_mispred_i,
  output logic [CNT_W-1:0] cnt_branch_o,
  output logic [CNT_W-1:0] cnt_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  // Counter encodings: weakly taken = MSB set only, weakly not-taken = its
  // bitwise complement, saturation limit = all ones.
  localparam logic [CTR_W-1:0] c_WEAK_TAKEN     = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] c_WEAK_NOT_TAKEN = ~c_WEAK_TAKEN;
  localparam logic [CTR_W-1:0] c_CTR_MAX        = '1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];
  logic [CNT_W-1:0]   r_cnt_branch;
  logic [CNT_W-1:0]   r_cnt_mispred;

  // Lookup side
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_taken;

  assign w_idx   = pc_i[IDX_W+1:2];
  assign w_tag   = pc_i[PC_W-1:IDX_W+2];
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_taken = w_hit && r_ctr[w_idx][CTR_W-1];

  assign hit_o        = w_hit;
  assign pred_taken_o = w_taken;
  // Fall-through wraps naturally at the top of the address space.
  assign pred_pc_o    = w_taken ? r_target[w_idx] : (pc_i + PC_W'(4));

  // Update side
  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;

  assign w_uidx = upd_pc_i[IDX_W+1:2];
  assign w_utag = upd_pc_i[PC_W-1:IDX_W+2];
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  // Byte-offset bits of the PCs carry no information for the table.
  logic w_unused;
  assign w_unused = &{1'b0, pc_i[1:0], upd_pc_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid       <= '0;
      r_cnt_branch  <= '0;
      r_cnt_mispred <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= c_WEAK_NOT_TAKEN;
      end
    end else if (upd_valid_i) begin
      r_cnt_branch <= r_cnt_branch + CNT_W'(1);
      if (upd_mispred_i) begin
        r_cnt_mispred <= r_cnt_mispred + CNT_W'(1);
      end
      if (w_uhit) begin
        if (upd_taken_i) begin
          if (r_ctr[w_uidx] != c_CTR_MAX) begin
            r_ctr[w_uidx] <= r_ctr[w_uidx] + CTR_W'(1);
          end
          r_target[w_uidx] <= upd_target_i;
        end else if (r_ctr[w_uidx] != '0) begin
          r_ctr[w_uidx] <= r_ctr[w_uidx] - CTR_W'(1);
        end
      end else if (upd_taken_i) begin
        // Taken miss allocates, evicting whatever aliased into this slot.
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target_i;
        r_ctr[w_uidx]    <= c_WEAK_TAKEN;
      end
    end
  end

  assign cnt_branch_o  = r_cnt_branch;
  assign cnt_mispred_o = r_cnt_mispred;

endmodule
`default_nettype wire
